tt_um_seg_decoder: RTL and testbench

Sequential seven-segment pattern decoder: the receive end of the one-hot-to-segment encoder tiles. Samples a segment bus on `ui_in`, synchronizes and debounces it, and converts each stable pattern back to its digit value. Each decoded digit is presented with a valid/ack handshake. Sits as a standalone TinyTapeout tile that recovers digits from segment lines driven by an encoder tile or an external display driver.

---
 rtl/tt_um_seg_decoder.sv | 166 ++++++++++++++++
 tb/tb_tt_um_seg_decoder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/tt_um_seg_decoder.sv
// Seven-segment pattern decoder tile: synchronizes and debounces ui_in[6:0], decodes stable
// patterns to digits with a valid/ack handshake. Define SEG_DECODE_HEX_EN to decode 8-F as well.
module tt_um_seg_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [3:0] STABLE_LIMIT = 4'(STABLE_CYCLES);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        HOLD        = 2'd1,
        WAIT_CHANGE = 2'd2
    } state_t;

    logic [6:0] sync1_q;
    logic [6:0] seg_s_q;
    logic [3:0] cnt_q;
    state_t     state_q;
    state_t     state_d;
    logic [6:0] code_q;
    logic [6:0] code_d;
    logic [3:0] digit_q;
    logic [3:0] digit_d;
    logic       error_q;
    logic       error_d;
    logic       overrun_q;
    logic       overrun_d;
    logic       valid_q;
    logic       valid_d;

    logic       stable;
    logic       ack;
    logic       dec_ok;
    logic [3:0] dec_digit;

    logic unused_bits;
    assign unused_bits = &{1'b0, ena, ui_in[7], uio_in[7:1]};

    assign ack    = uio_in[0];
    assign stable = (cnt_q == STABLE_LIMIT);

    // The counter restarts on the edge where seg_s takes a new value, which keeps
    // the input-change-to-valid latency at STABLE_CYCLES + 3 edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            seg_s_q <= '0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= ui_in[6:0];
            seg_s_q <= sync1_q;
            if (sync1_q != seg_s_q) begin
                cnt_q <= '0;
            end else if (cnt_q != STABLE_LIMIT) begin
                cnt_q <= cnt_q + 4'd1;
            end
        end
    end

    always_comb begin
        dec_ok    = 1'b1;
        dec_digit = 4'd0;
        case (seg_s_q)
            7'h3F: dec_digit = 4'h0;
            7'h06: dec_digit = 4'h1;
            7'h5B: dec_digit = 4'h2;
            7'h4F: dec_digit = 4'h3;
            7'h66: dec_digit = 4'h4;
            7'h6D: dec_digit = 4'h5;
            7'h7D: dec_digit = 4'h6;
            7'h07: dec_digit = 4'h7;
`ifdef SEG_DECODE_HEX_EN
            7'h7F: dec_digit = 4'h8;
            7'h6F: dec_digit = 4'h9;
            7'h77: dec_digit = 4'hA;
            7'h7C: dec_digit = 4'hB;
            7'h39: dec_digit = 4'hC;
            7'h5E: dec_digit = 4'hD;
            7'h79: dec_digit = 4'hE;
            7'h71: dec_digit = 4'hF;
`endif
            default: dec_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (stable && (seg_s_q != 7'h00)) state_d = HOLD;
            end
            HOLD: begin
                if (ack) state_d = WAIT_CHANGE;
            end
            WAIT_CHANGE: begin
                if (seg_s_q != code_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        code_d    = code_q;
        digit_d   = digit_q;
        error_d   = error_q;
        overrun_d = overrun_q;
        case (state_q)
            IDLE: begin
                if (stable && (seg_s_q != 7'h00)) begin
                    code_d    = seg_s_q;
                    digit_d   = dec_ok ? dec_digit : 4'd0;
                    error_d   = ~dec_ok;
                    overrun_d = 1'b0;
                end
            end
            HOLD: begin
                // Ack beats a simultaneous overrun; the newer pattern is dropped.
                if (ack) begin
                    overrun_d = 1'b0;
                end else if (stable && (seg_s_q != code_q)) begin
                    overrun_d = 1'b1;
                end
            end
            default: ;
        endcase
        valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q    <= '0;
            digit_q   <= '0;
            error_q   <= 1'b0;
            overrun_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            code_q    <= code_d;
            digit_q   <= digit_d;
            error_q   <= error_d;
            overrun_q <= overrun_d;
            valid_q   <= valid_d;
        end
    end

    assign uo_out  = {1'b0, overrun_q, error_q, valid_q, digit_q};
    assign uio_out = {6'b0, valid_q, 1'b0};
    assign uio_oe  = 8'b0000_0010;

endmodule

// File: tb/tb_tt_um_seg_decoder.sv
// Directed bench for tt_um_seg_decoder: vector table over the decode map plus
// hand-written latency, glitch, overrun and reset sequences.
module tb_tt_um_seg_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int tests = 0;
    int fails = 0;

    tt_um_seg_decoder #(.STABLE_CYCLES(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .uo_out (uo_out),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] seg;
        logic [3:0] digit;
        logic       err;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!uo_out[4] && n < 20) begin
            tick();
            n++;
        end
        check({name, "_valid"}, uo_out[4], 1'b1);
    endtask

    task automatic do_ack();
        uio_in = 8'h01;
        tick();
        uio_in = 8'h00;
    endtask

    // Return to IDLE with a stable blank, acknowledging anything left pending.
    task automatic flush();
        ui_in = 8'h00;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (uo_out[4]) do_ack();
        end
    endtask

    initial begin
        logic seen;

        vecs[0]  = '{7'h3F, 4'h0, 1'b0};
        vecs[1]  = '{7'h06, 4'h1, 1'b0};
        vecs[2]  = '{7'h5B, 4'h2, 1'b0};
        vecs[3]  = '{7'h4F, 4'h3, 1'b0};
        vecs[4]  = '{7'h66, 4'h4, 1'b0};
        vecs[5]  = '{7'h6D, 4'h5, 1'b0};
        vecs[6]  = '{7'h7D, 4'h6, 1'b0};
        vecs[7]  = '{7'h07, 4'h7, 1'b0};
        vecs[8]  = '{7'h01, 4'h0, 1'b1};
`ifdef SEG_DECODE_HEX_EN
        vecs[9]  = '{7'h77, 4'hA, 1'b0};
        vecs[10] = '{7'h7F, 4'h8, 1'b0};
        vecs[11] = '{7'h71, 4'hF, 1'b0};
`else
        vecs[9]  = '{7'h77, 4'h0, 1'b1};
        vecs[10] = '{7'h7F, 4'h0, 1'b1};
        vecs[11] = '{7'h71, 4'h0, 1'b1};
`endif

        // Reset with random input activity.
        for (int i = 0; i < 5; i++) begin
            ui_in = 8'($urandom);
            tick();
        end
        check("reset_uo_out", uo_out, 8'h00);
        check("reset_uio_out", uio_out, 8'h00);
        check("reset_uio_oe", uio_oe, 8'h02);
        ui_in = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        flush();

        // Latency: valid must be low after edge 6 and high after edge 7.
        ui_in = 8'h5B;
        for (int e = 1; e <= 6; e++) tick();
        check("lat_edge6_valid", uo_out[4], 1'b0);
        tick();
        check("lat_edge7_valid", uo_out[4], 1'b1);
        check("lat_digit", uo_out[3:0], 4'h2);
        check("lat_uio_valid", uio_out, 8'h02);
        for (int i = 0; i < 3; i++) tick();
        check("hold_valid", uo_out[4], 1'b1);
        do_ack();
        check("ack_valid_low", uo_out[4], 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            seen |= uo_out[4];
        end
        check("no_repeat_valid", seen, 1'b0);
        flush();

        // Decode table.
        for (int v = 0; v < 12; v++) begin
            ui_in = {1'b0, vecs[v].seg};
            wait_valid($sformatf("vec%0d", v));
            check($sformatf("vec%0d_digit", v), uo_out[3:0], vecs[v].digit);
            check($sformatf("vec%0d_error", v), uo_out[5], vecs[v].err);
            check($sformatf("vec%0d_bits76", v), uo_out[7:6], 2'b00);
            do_ack();
            check($sformatf("vec%0d_ack", v), uo_out[4], 1'b0);
            flush();
        end

        // Glitch of 3 samples inside a blank stream.
        ui_in = 8'h4F;
        for (int i = 0; i < 3; i++) tick();
        ui_in = 8'h00;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            seen |= uo_out[4];
        end
        check("glitch_no_valid", seen, 1'b0);

        // Overrun while holding digit 6.
        ui_in = 8'h7D;
        wait_valid("ovr");
        check("ovr_digit_before", uo_out[3:0], 4'h6);
        check("ovr_flag_before", uo_out[6], 1'b0);
        ui_in = 8'h07;
        for (int i = 0; i < 10; i++) tick();
        check("ovr_flag", uo_out[6], 1'b1);
        check("ovr_digit_kept", uo_out[3:0], 4'h6);
        check("ovr_valid_kept", uo_out[4], 1'b1);
        do_ack();
        check("ovr_cleared", uo_out[6], 1'b0);
        check("ovr_ack_valid", uo_out[4], 1'b0);
        flush();

        // Reset mid-HOLD clears outputs without waiting for a clock edge.
        ui_in = 8'h3F;
        wait_valid("rst_hold");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_uo_out", uo_out, 8'h00);
        check("midrst_uio_out", uio_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        ui_in = 8'h00;
        flush();
        check("post_rst_idle", uo_out[4], 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
